// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
//   Issue-and-writeback sequencer in front of the 16-bit combinational ALU.
//   Accepts one instruction at a time, reads operands from an internal
//   register file, drives the ALU operand/control ports from registers,
//   captures the ALU result and zero flag, and writes the result back.
//   Each instruction takes three cycles: IDLE (accept) -> EXEC -> WB.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   instruction handshake (ready only in IDLE)
//   in_op                 ALU control code, passed through unmodified
//   in_rd/in_rs1/in_rs2   destination and source register indices
//   in_use_imm, in_imm    select immediate as operand B
//   alu_a, alu_b          registered operands to the ALU
//   alu_control           registered op code to the ALU
//   alu_result, alu_zero  combinational ALU outputs
//   wb_valid/wb_rd/wb_data write-back being presented (WB state)
//   zero_flag             zero status of the last completed instruction
//   dbg_addr / dbg_data   combinational register file read port
// ---------------------------------------------------------------------------
module alu_issue #(
  parameter int NUM_REGS = 8,
  localparam int IW = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [IW-1:0] in_rd,
  input  logic [IW-1:0] in_rs1,
  input  logic [IW-1:0] in_rs2,
  input  logic          in_use_imm,
  input  logic [15:0]   in_imm,
  output logic [15:0]   alu_a,
  output logic [15:0]   alu_b,
  output logic [2:0]    alu_control,
  input  logic [15:0]   alu_result,
  input  logic          alu_zero,
  output logic          wb_valid,
  output logic [IW-1:0] wb_rd,
  output logic [15:0]   wb_data,
  output logic          zero_flag,
  input  logic [IW-1:0] dbg_addr,
  output logic [15:0]   dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t        state_reg;
  state_t        state_next;

  logic [15:0]   rf [NUM_REGS];
  logic [IW-1:0] rd_reg;
  logic [15:0]   result_reg;
  logic          zero_pend_reg;
  logic          accept;
  logic          wb_we;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- state-decoded outputs ----------------
  always_comb begin
    in_ready = (state_reg == IDLE);
    wb_valid = (state_reg == WB);
    accept   = (state_reg == IDLE) && in_valid;
    // r0 is never written, so it reads back as its reset value of zero.
    wb_we    = (state_reg == WB) && (rd_reg != '0);
  end

  // ---------------- operand issue and result capture ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_control   <= '0;
      rd_reg        <= '0;
      result_reg    <= '0;
      zero_pend_reg <= 1'b0;
      zero_flag     <= 1'b0;
    end else begin
      if (accept) begin
        // Operands reflect the register file as it stands at the accept
        // edge; any earlier write-back has already landed by then.
        alu_a       <= rf[in_rs1];
        alu_b       <= in_use_imm ? in_imm : rf[in_rs2];
        alu_control <= in_op;
        rd_reg      <= in_rd;
      end
      if (state_reg == EXEC) begin
        result_reg    <= alu_result;
        zero_pend_reg <= alu_zero;
      end
      // The zero status follows every completed instruction, r0 included.
      if (state_reg == WB) zero_flag <= zero_pend_reg;
    end
  end

  // ---------------- register file ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wb_we) begin
      rf[rd_reg] <= result_reg;
    end
  end

  assign wb_rd    = rd_reg;
  assign wb_data  = result_reg;
  assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue
//   Self-checking bench for alu_issue. The bench plays the role of the
//   combinational ALU and keeps a plain array model of the register file;
//   expected results are computed from the architectural rules.
// ---------------------------------------------------------------------------
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [2:0]  in_rd, in_rs1, in_rs2;
  logic        in_use_imm;
  logic [15:0] in_imm;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_control;
  logic [15:0] alu_result;
  logic        alu_zero;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        zero_flag;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int errors = 0;
  int checks = 0;

  logic [15:0] mreg [8];

  always #5 clk = ~clk;

  alu_issue #(.NUM_REGS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .zero_flag(zero_flag),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  function automatic logic [15:0] ref_alu(input logic [2:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return p[15:0];
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      default: return 16'h0000;
    endcase
  endfunction

  // Stand-in for the real combinational ALU.
  always_comb begin
    alu_result = ref_alu(alu_control, alu_a, alu_b);
    alu_zero   = (alu_result == 16'h0000);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction through IDLE -> EXEC -> WB with checks at each phase.
  task automatic issue(input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic use_imm, input logic [15:0] imm);
    logic [15:0] a, b, r;
    @(negedge clk);
    a = mreg[rs1];
    b = use_imm ? imm : mreg[rs2];
    r = ref_alu(op, a, b);
    chk("ready_idle", 16'(in_ready), 16'h1);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_use_imm = use_imm; in_imm = imm; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    chk("alu_control", 16'(alu_control), 16'(op));
    chk("exec_wb_valid", 16'(wb_valid), 16'h0);
    chk("exec_ready", 16'(in_ready), 16'h0);
    @(negedge clk);
    chk("wb_valid", 16'(wb_valid), 16'h1);
    chk("wb_rd", 16'(wb_rd), 16'(rd));
    chk("wb_data", wb_data, r);
    @(negedge clk);
    chk("wb_pulse_end", 16'(wb_valid), 16'h0);
    chk("ready_after", 16'(in_ready), 16'h1);
    chk("zero_flag", 16'(zero_flag), 16'(r == 16'h0000));
    if (rd != 3'd0) mreg[rd] = r;
    dbg_addr = rd;
    #1;
    chk("dbg_rd", dbg_data, mreg[rd]);
    $display("op=%0d rd=r%0d a=%h b=%h -> result=%h zero=%0b", op, rd, a, b, r, zero_flag);
  endtask

  logic [2:0]  s_op [4];
  logic [2:0]  s_rd [4], s_rs1 [4], s_rs2 [4];
  logic        s_ui [4];
  logic [15:0] s_imm [4];
  logic [15:0] s_exp [4];
  int          acc_cyc [4];

  initial begin
    int cyc, idx, nwb;
    bit load_next;

    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0;
    in_rs2 = '0; in_use_imm = 1'b0; in_imm = '0; dbg_addr = '0;
    for (int i = 0; i < 8; i++) mreg[i] = 16'h0000;

    // ---------------- reset state ----------------
    #1;
    chk("ready_in_reset", 16'(in_ready), 16'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 16'(in_ready), 16'h1);
    chk("reset_zero_flag", 16'(zero_flag), 16'h0);
    chk("reset_wb_valid", 16'(wb_valid), 16'h0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk("reset_dbg", dbg_data, 16'h0000);
    end

    // ---------------- directed sequence ----------------
    issue(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005);   // add r1 = r0 + 5
    issue(3'd1, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0005);   // sub r2 = r1 - 5 -> 0
    issue(3'd0, 3'd3, 3'd0, 3'd0, 1'b1, 16'h0100);   // r3 = 0x0100
    issue(3'd0, 3'd4, 3'd0, 3'd0, 1'b1, 16'h0200);   // r4 = 0x0200
    issue(3'd2, 3'd5, 3'd3, 3'd4, 1'b0, 16'h0000);   // mul r5 = r3*r4 -> 0
    issue(3'd0, 3'd6, 3'd0, 3'd0, 1'b1, 16'hFFFF);   // r6 = 0xFFFF
    issue(3'd0, 3'd6, 3'd6, 3'd0, 1'b1, 16'h0001);   // r6 = r6 + 1 -> 0
    issue(3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 16'h1234);   // r0 write discarded
    issue(3'd5, 3'd7, 3'd1, 3'd3, 1'b0, 16'h0000);   // xor r7 = r1 ^ r3

    // ---------------- randomized instructions ----------------
    for (int k = 0; k < 12; k++)
      issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 16'($urandom));

    // ---------------- continuous in_valid, dependent chain ----------------
    s_op[0] = 3'd0; s_rd[0] = 3'd1; s_rs1[0] = 3'd0; s_rs2[0] = 3'd0; s_ui[0] = 1'b1; s_imm[0] = 16'($urandom);
    s_op[1] = 3'd0; s_rd[1] = 3'd2; s_rs1[1] = 3'd1; s_rs2[1] = 3'd0; s_ui[1] = 1'b1; s_imm[1] = 16'($urandom);
    s_op[2] = 3'd5; s_rd[2] = 3'd3; s_rs1[2] = 3'd1; s_rs2[2] = 3'd2; s_ui[2] = 1'b0; s_imm[2] = 16'h0000;
    s_op[3] = 3'd1; s_rd[3] = 3'd4; s_rs1[3] = 3'd3; s_rs2[3] = 3'd1; s_ui[3] = 1'b0; s_imm[3] = 16'h0000;
    for (int i = 0; i < 4; i++) begin acc_cyc[i] = -100; s_exp[i] = 16'h0000; end

    @(negedge clk);
    in_op = s_op[0]; in_rd = s_rd[0]; in_rs1 = s_rs1[0]; in_rs2 = s_rs2[0];
    in_use_imm = s_ui[0]; in_imm = s_imm[0]; in_valid = 1'b1;
    cyc = 0; idx = 0; nwb = 0; load_next = 1'b0;
    while (nwb < 4 && cyc < 60) begin
      if (load_next) begin
        if (idx < 4) begin
          in_op = s_op[idx]; in_rd = s_rd[idx]; in_rs1 = s_rs1[idx]; in_rs2 = s_rs2[idx];
          in_use_imm = s_ui[idx]; in_imm = s_imm[idx];
        end else begin
          in_valid = 1'b0;
        end
        load_next = 1'b0;
      end
      if (wb_valid) begin
        chk("stream_wb_rd", 16'(wb_rd), 16'(s_rd[nwb]));
        chk("stream_wb_data", wb_data, s_exp[nwb]);
        if (s_rd[nwb] != 3'd0) mreg[s_rd[nwb]] = s_exp[nwb];
        $display("stream wb #%0d rd=r%0d data=%h", nwb, wb_rd, wb_data);
        nwb++;
      end
      if (in_ready && in_valid && idx < 4) begin
        s_exp[idx] = ref_alu(s_op[idx], mreg[s_rs1[idx]],
                             s_ui[idx] ? s_imm[idx] : mreg[s_rs2[idx]]);
        acc_cyc[idx] = cyc;
        idx++;
        load_next = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    chk("stream_accepts", 16'(idx), 16'd4);
    chk("stream_writebacks", 16'(nwb), 16'd4);
    for (int i = 1; i < 4; i++)
      chk("stream_spacing", 16'(acc_cyc[i] - acc_cyc[i-1]), 16'd3);
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stream_no_extra_wb", 16'(wb_valid), 16'h0);
    end

    // ---------------- reset during EXEC ----------------
    issue(3'd6, 3'd5, 3'd1, 3'd2, 1'b0, 16'h0000);   // undefined op -> 0, zero_flag 1
    @(negedge clk);
    in_op = 3'd5; in_rd = 3'd7; in_rs1 = 3'd0; in_rs2 = 3'd0;
    in_use_imm = 1'b1; in_imm = 16'hAAAA; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_reset_alu_b", alu_b, 16'hAAAA);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_alu_a", alu_a, 16'h0000);
    chk("arst_alu_b", alu_b, 16'h0000);
    chk("arst_alu_control", 16'(alu_control), 16'h0);
    chk("arst_wb_valid", 16'(wb_valid), 16'h0);
    chk("arst_wb_rd", 16'(wb_rd), 16'h0);
    chk("arst_wb_data", wb_data, 16'h0000);
    chk("arst_zero_flag", 16'(zero_flag), 16'h0);
    chk("arst_ready", 16'(in_ready), 16'h1);
    for (int i = 0; i < 8; i++) mreg[i] = 16'h0000;
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_wb_valid", 16'(wb_valid), 16'h0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_wb_valid", 16'(wb_valid), 16'h0);
    end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk("post_rst_dbg", dbg_data, 16'h0000);
    end
    issue(3'd4, 3'd7, 3'd0, 3'd0, 1'b1, 16'h5A5A);   // recovery after reset

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
